// File: rtl/string_led_pkg.sv
// string_led_pkg
// Shared constants for the string-LED sequencer and its bit encoder:
//   - FSM state encodings (ST_IDLE, ST_FETCH, ST_WAIT, ST_SEND)
//   - phase encoding within one LED bit (PH_HIGH, PH_DATA, PH_LOW)
//   - BITS_PER_BYTE
package string_led_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_SEND  = 2'd3;

  typedef enum logic [1:0] {
    PH_HIGH = 2'd0,
    PH_DATA = 2'd1,
    PH_LOW  = 2'd2
  } phase_t;

  localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/string_led_bit_encoder.sv
// string_led_bit_encoder
// Serialises one byte MSB-first as WS2812-style symbols. Each bit is three
// phases of phase_len clocks: HIGH (raw 1), DATA (raw = bit), LOW (raw 0).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clear          abort: drop the byte in flight, raw goes 0 next cycle
//   load           one-cycle pulse, captures data and starts the byte
//   data           byte to send
//   phase_len      phase length in clocks (>= 1)
//   raw            un-inverted serial level
//   byte_done      high during the final clock of the last phase of bit 0
module string_led_bit_encoder
  import string_led_pkg::*;
#(
  parameter int PSIZE = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [7:0]       data,
  input  logic [PSIZE:0]   phase_len,
  output logic             raw,
  output logic             byte_done
);

  logic           active;
  logic [7:0]     shift;
  logic [2:0]     bit_idx;
  phase_t         phase;
  logic [PSIZE:0] cnt;
  logic           phase_end;

  // phase_len is one bit wider than the prescaler, so the all-ones prescaler
  // still yields a correct 2^PSIZE-cycle phase without wrapping.
  assign phase_end = (cnt == phase_len - {{PSIZE{1'b0}}, 1'b1});
  assign byte_done = active && phase_end && (phase == PH_LOW) && (bit_idx == 3'd0);
  // shift[7] is always the bit currently being encoded.
  assign raw = active && ((phase == PH_HIGH) || ((phase == PH_DATA) && shift[7]));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      active  <= 1'b0;
      shift   <= 8'd0;
      bit_idx <= 3'd0;
      phase   <= PH_HIGH;
      cnt     <= '0;
    end else if (load) begin
      active  <= 1'b1;
      shift   <= data;
      bit_idx <= 3'(BITS_PER_BYTE - 1);
      phase   <= PH_HIGH;
      cnt     <= '0;
    end else if (active) begin
      if (phase_end) begin
        cnt <= '0;
        case (phase)
          PH_HIGH: phase <= PH_DATA;
          PH_DATA: phase <= PH_LOW;
          default: begin
            phase <= PH_HIGH;
            shift <= {shift[6:0], 1'b0};
            if (bit_idx == 3'd0) active <= 1'b0;
            else                 bit_idx <= bit_idx - 3'd1;
          end
        endcase
      end else begin
        cnt <= cnt + {{PSIZE{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/string_led_sequencer.sv
// string_led_sequencer
// Walks SRAM words w_first..w_last (inclusive, wrapping through address 0 if
// w_last < w_first) w_count times, sending each byte on led_out.
// SRAM port protocol: one-cycle cs_n=0 with addr valid; rdata is valid on the
// following cycle. No back-pressure, one read per byte.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   controller_en       low aborts to IDLE (no done)
//   prescaler           phase length minus 1
//   polarity            1 inverts led_out (combinational)
//   w_count             iterations (0 means start is ignored)
//   w_first, w_last     address window
//   start               start strobe, honoured only in IDLE
//   progress            high while a sequence runs
//   done                one-cycle pulse on normal completion
//   cs_n, addr, rdata   SRAM read port 1
//   led_out             serial LED stream
//   state               FSM state, for observation
module string_led_sequencer
  import string_led_pkg::*;
#(
  parameter int ASIZE = 32,
  parameter int PSIZE = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             controller_en,
  input  logic [PSIZE-1:0] prescaler,
  input  logic             polarity,
  input  logic [3:0]       w_count,
  input  logic [ASIZE-1:0] w_first,
  input  logic [ASIZE-1:0] w_last,
  input  logic             start,
  output logic             progress,
  output logic             done,
  output logic             cs_n,
  output logic [ASIZE-1:0] addr,
  input  logic [7:0]       rdata,
  output logic             led_out,
  output logic [1:0]       state
);

  logic [ASIZE-1:0] cur_addr;
  logic [ASIZE-1:0] first_q;
  logic [ASIZE-1:0] last_q;
  logic [PSIZE-1:0] pre_q;
  logic [3:0]       iter;
  logic [PSIZE:0]   phase_len;
  logic             raw;
  logic             byte_done;

  assign phase_len = {1'b0, pre_q} + {{PSIZE{1'b0}}, 1'b1};
  assign progress  = (state != ST_IDLE);
  assign cs_n      = (state != ST_FETCH);
  assign addr      = cur_addr;
  assign led_out   = raw ^ polarity;

  string_led_bit_encoder #(.PSIZE(PSIZE)) u_enc (
    .clk       (clk),
    .rst       (rst),
    .clear     (!controller_en),
    .load      (state == ST_WAIT),
    .data      (rdata),
    .phase_len (phase_len),
    .raw       (raw),
    .byte_done (byte_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      done     <= 1'b0;
      cur_addr <= '0;
      first_q  <= '0;
      last_q   <= '0;
      pre_q    <= '0;
      iter     <= 4'd0;
    end else begin
      done <= 1'b0;
      if (!controller_en) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            // Snapshot the configuration so register writes during a run
            // cannot disturb it.
            if (start && (w_count != 4'd0)) begin
              state    <= ST_FETCH;
              cur_addr <= w_first;
              first_q  <= w_first;
              last_q   <= w_last;
              pre_q    <= prescaler;
              iter     <= w_count;
            end
          end
          ST_FETCH: state <= ST_WAIT;
          ST_WAIT:  state <= ST_SEND;
          default: begin
            if (byte_done) begin
              if (cur_addr != last_q) begin
                cur_addr <= cur_addr + {{(ASIZE-1){1'b0}}, 1'b1};
                state    <= ST_FETCH;
              end else if (iter > 4'd1) begin
                iter     <= iter - 4'd1;
                cur_addr <= first_q;
                state    <= ST_FETCH;
              end else begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule
